irq_sb_ctrl: RTL and testbench

Interrupt controller between the peripheral controllers and the core's single interrupt input.
- Collects level-sensitive `interrupt_request_o` lines from up to N_SRC peripherals into `irq_src_i`.
- Applies a software mask and selects one source by priority.
- Drives the core's irq request; on the core's return signal, it pulses the matching per-source acknowledge.
- Is itself a system-bus slave (mask/pending/cause registers) in its own peripheral address slot.

---
 rtl/irq_sb_ctrl_if.sv | 25 ++
 rtl/irq_sb_ctrl.sv | 134 +++++++++++++
 tb/tb_irq_sb_ctrl.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/irq_sb_ctrl_if.sv
// System-bus slave port of the interrupt controller: request, direction,
// address and write data in; registered read data out.
interface irq_sb_ctrl_if;
   logic        req_i;
   logic        write_enable_i;
   logic [31:0] addr_i;
   logic [31:0] write_data_i;
   logic [31:0] read_data_o;

   modport master (
      output req_i,
      output write_enable_i,
      output addr_i,
      output write_data_i,
      input  read_data_o
   );

   modport slave (
      input  req_i,
      input  write_enable_i,
      input  addr_i,
      input  write_data_i,
      output read_data_o
   );
endinterface

// File: rtl/irq_sb_ctrl.sv
// Interrupt controller: masks and prioritises level-sensitive peripheral
// requests, drives the core irq line and pulses the serviced source's ack on return.
module irq_sb_ctrl #(
   parameter int N_SRC = 8,
   parameter int RR_EN = 0
) (
   input  logic             clk_i,
   input  logic             resetn_i,
   irq_sb_ctrl_if.slave     bus_if,
   input  logic [N_SRC-1:0] irq_src_i,
   output logic [N_SRC-1:0] irq_ack_o,
   output logic             irq_req_o,
   input  logic             irq_ret_i
);

   typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

   state_t             state_q, state_d;
   logic [N_SRC-1:0]   mask_q, mask_d;
   logic [4:0]         cur_id_q, cur_id_d;
   logic [4:0]         last_id_q, last_id_d;
   logic               irq_req_q, irq_req_d;
   logic [N_SRC-1:0]   irq_ack_q, irq_ack_d;
   logic [31:0]        read_data_q, read_data_d;

   logic [N_SRC-1:0]   pend;
   logic [31:0]        pend32;
   logic [4:0]         start;
   logic [5:0]         pos;
   logic [4:0]         sel_id;
   logic               found;
   logic [31:0]        ack32;
   logic               unused_bits;

   assign pend = irq_src_i & mask_q;
   assign bus_if.read_data_o = read_data_q;
   assign irq_req_o = irq_req_q;
   assign irq_ack_o = irq_ack_q;
   assign unused_bits = ^{bus_if.addr_i[31:24], bus_if.write_data_i};

   // Scan pending sources from the start index upward with wrap-around;
   // fixed priority simply always starts at index 0.
   always_comb begin
      pend32 = '0;
      pend32[N_SRC-1:0] = pend;
      start = '0;
      if (RR_EN != 0 && last_id_q != 5'(N_SRC - 1)) begin
         start = last_id_q + 5'd1;
      end
      pos = '0;
      sel_id = '0;
      found = 1'b0;
      for (int k = 0; k < N_SRC; k++) begin
         pos = {1'b0, start} + 6'(k);
         if (pos >= 6'(N_SRC)) begin
            pos = pos - 6'(N_SRC);
         end
         if (!found && pend32[pos[4:0]]) begin
            found = 1'b1;
            sel_id = pos[4:0];
         end
      end
   end

   // Register access; selection in IDLE always sees the mask from before a same-cycle write.
   always_comb begin
      mask_d = mask_q;
      read_data_d = read_data_q;
      if (bus_if.req_i && bus_if.write_enable_i && bus_if.addr_i[23:0] == 24'h0) begin
         mask_d = bus_if.write_data_i[N_SRC-1:0];
      end
      if (bus_if.req_i && !bus_if.write_enable_i) begin
         case (bus_if.addr_i[23:0])
            24'h00:  read_data_d = 32'(mask_q);
            24'h04:  read_data_d = 32'(pend);
            24'h08:  read_data_d = {state_q == ACTIVE, 26'd0, cur_id_q};
            default: read_data_d = 32'd0;
         endcase
      end
   end

   // irq_req_o trails entry into ACTIVE by one edge and drops together with the ack.
   always_comb begin
      state_d = state_q;
      cur_id_d = cur_id_q;
      last_id_d = last_id_q;
      irq_ack_d = '0;
      irq_req_d = 1'b0;
      ack32 = 32'd1 << cur_id_q;
      case (state_q)
         IDLE: begin
            if (found) begin
               cur_id_d = sel_id;
               state_d = ACTIVE;
            end
         end
         ACTIVE: begin
            irq_req_d = !irq_ret_i;
            if (irq_ret_i) begin
               irq_ack_d = ack32[N_SRC-1:0];
               last_id_d = cur_id_q;
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         state_q <= IDLE;
         mask_q <= '0;
         cur_id_q <= '0;
         last_id_q <= 5'(N_SRC - 1);
         irq_req_q <= 1'b0;
         irq_ack_q <= '0;
         read_data_q <= '0;
      end else begin
         state_q <= state_d;
         mask_q <= mask_d;
         cur_id_q <= cur_id_d;
         last_id_q <= last_id_d;
         irq_req_q <= irq_req_d;
         irq_ack_q <= irq_ack_d;
         read_data_q <= read_data_d;
      end
   end

endmodule

// File: tb/tb_irq_sb_ctrl.sv
// Bench for irq_sb_ctrl: a fixed-priority and a round-robin instance driven in
// lockstep, checked against a transaction-level model plus directed expectations.
module tb_irq_sb_ctrl;
   localparam int N = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          resetn;
   logic          busReq, busWe;
   logic [31:0]   busAddr, busWdata;
   logic [N-1:0]  src;
   logic          ret;
   logic [N-1:0]  ack0, ack1;
   logic          req0, req1;

   int checks = 0;
   int errors = 0;

   irq_sb_ctrl_if bus0();
   irq_sb_ctrl_if bus1();

   assign bus0.req_i = busReq;
   assign bus0.write_enable_i = busWe;
   assign bus0.addr_i = busAddr;
   assign bus0.write_data_i = busWdata;
   assign bus1.req_i = busReq;
   assign bus1.write_enable_i = busWe;
   assign bus1.addr_i = busAddr;
   assign bus1.write_data_i = busWdata;

   irq_sb_ctrl #(.N_SRC(N), .RR_EN(0)) dut (
      .clk_i(clk), .resetn_i(resetn), .bus_if(bus0),
      .irq_src_i(src), .irq_ack_o(ack0), .irq_req_o(req0), .irq_ret_i(ret)
   );

   irq_sb_ctrl #(.N_SRC(N), .RR_EN(1)) dutRr (
      .clk_i(clk), .resetn_i(resetn), .bus_if(bus1),
      .irq_src_i(src), .irq_ack_o(ack1), .irq_req_o(req1), .irq_ret_i(ret)
   );

   // Model: per instance, whether a source is being serviced, which one, the
   // last one finished, and whether we are in the one-cycle cool-down after a return.
   logic [N-1:0]  mMask [2];
   int            mCur [2];
   int            mLast [2];
   bit            mBusy [2];
   bit            mCool [2];
   logic          mReq [2];
   logic [N-1:0]  mAck [2];
   logic [31:0]   mRd [2];

   logic [7:0] expRr [4] = '{8'h08, 8'h20, 8'h08, 8'h20};

   function automatic int pickSource(input logic [N-1:0] pend, input int last, input bit rr);
      int i;
      for (int k = 0; k < N; k++) begin
         i = rr ? (last + 1 + k) % N : k;
         if (pend[i]) return i;
      end
      return -1;
   endfunction

   task automatic resetModel();
      for (int m = 0; m < 2; m++) begin
         mMask[m] = '0;
         mCur[m] = 0;
         mLast[m] = N - 1;
         mBusy[m] = 1'b0;
         mCool[m] = 1'b0;
         mReq[m] = 1'b0;
         mAck[m] = '0;
         mRd[m] = '0;
      end
   endtask

   task automatic updateModel();
      logic [N-1:0] pend;
      int           pick;
      for (int m = 0; m < 2; m++) begin
         pend = src & mMask[m];
         if (busReq && !busWe) begin
            case (busAddr)
               32'h0:   mRd[m] = {24'd0, mMask[m]};
               32'h4:   mRd[m] = {24'd0, pend};
               32'h8:   mRd[m] = {mBusy[m], 26'd0, 5'(mCur[m])};
               default: mRd[m] = 32'd0;
            endcase
         end
         mAck[m] = '0;
         mReq[m] = 1'b0;
         if (mCool[m]) begin
            mCool[m] = 1'b0;
         end else if (mBusy[m]) begin
            if (ret) begin
               mAck[m] = N'(1) << mCur[m];
               mLast[m] = mCur[m];
               mBusy[m] = 1'b0;
               mCool[m] = 1'b1;
            end else begin
               mReq[m] = 1'b1;
            end
         end else begin
            pick = pickSource(pend, mLast[m], m == 1);
            if (pick >= 0) begin
               mCur[m] = pick;
               mBusy[m] = 1'b1;
            end
         end
         if (busReq && busWe && busAddr == 32'h0) mMask[m] = busWdata[N-1:0];
      end
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic checkAll();
      checkOutput("req0", {31'd0, req0}, {31'd0, mReq[0]});
      checkOutput("ack0", {24'd0, ack0}, {24'd0, mAck[0]});
      checkOutput("rd0", bus0.read_data_o, mRd[0]);
      checkOutput("req1", {31'd0, req1}, {31'd0, mReq[1]});
      checkOutput("ack1", {24'd0, ack1}, {24'd0, mAck[1]});
      checkOutput("rd1", bus1.read_data_o, mRd[1]);
   endtask

   task automatic applyStimulus();
      @(posedge clk);
      updateModel();
      #1;
      checkAll();
   endtask

   task automatic busWrite(input logic [31:0] a, input logic [31:0] d);
      busReq = 1'b1; busWe = 1'b1; busAddr = a; busWdata = d;
      applyStimulus();
      busReq = 1'b0; busWe = 1'b0;
   endtask

   task automatic busRead(input logic [31:0] a);
      busReq = 1'b1; busWe = 1'b0; busAddr = a;
      applyStimulus();
      busReq = 1'b0;
   endtask

   task automatic waitReq();
      int n = 0;
      while (req0 !== 1'b1 && n < 10) begin
         applyStimulus();
         n++;
      end
      checkOutput("waitReq", {31'd0, req0}, 32'd1);
   endtask

   initial begin
      resetn = 1'b0; busReq = 0; busWe = 0; busAddr = 0; busWdata = 0; src = 0; ret = 0;
      resetModel();
      repeat (3) @(posedge clk);
      @(negedge clk) resetn = 1'b1;
      checkOutput("rstReq", {31'd0, req0}, 32'd0);
      checkOutput("rstAck", {24'd0, ack0}, 32'd0);
      checkOutput("rstRd", bus0.read_data_o, 32'd0);

      // Basic service of source 2 with a two-edge request latency
      busWrite(32'h0, 32'h05);
      src = 8'h04;
      applyStimulus();
      checkOutput("t1ReqEarly", {31'd0, req0}, 32'd0);
      applyStimulus();
      checkOutput("t1Req", {31'd0, req0}, 32'd1);
      busRead(32'h8);
      checkOutput("t1Cause", bus0.read_data_o, 32'h8000_0002);
      ret = 1'b1;
      applyStimulus();
      ret = 1'b0;
      checkOutput("t1Ack", {24'd0, ack0}, 32'h04);
      checkOutput("t1ReqDrop", {31'd0, req0}, 32'd0);
      src = 8'h00;
      applyStimulus();
      checkOutput("t1AckOnce", {24'd0, ack0}, 32'd0);
      applyStimulus();

      // Two held sources: fixed repeats 3, round-robin alternates 3 and 5
      busWrite(32'h0, 32'hFF);
      src = 8'h28;
      for (int i = 0; i < 4; i++) begin
         waitReq();
         ret = 1'b1;
         applyStimulus();
         ret = 1'b0;
         checkOutput("t2AckFixed", {24'd0, ack0}, 32'h08);
         checkOutput("t2AckRr", {24'd0, ack1}, {24'd0, expRr[i]});
      end
      src = 8'h00;
      repeat (3) applyStimulus();

      // Everything masked, then unmask only source 7
      busWrite(32'h0, 32'h00);
      src = 8'hFF;
      repeat (3) applyStimulus();
      checkOutput("t3NoReq", {31'd0, req0}, 32'd0);
      busRead(32'h4);
      checkOutput("t3Pending", bus0.read_data_o, 32'd0);
      busWrite(32'h0, 32'h80);
      applyStimulus();
      applyStimulus();
      checkOutput("t3Req", {31'd0, req0}, 32'd1);
      busRead(32'h8);
      checkOutput("t3Cause", bus0.read_data_o, 32'h8000_0007);
      ret = 1'b1;
      applyStimulus();
      ret = 1'b0;
      checkOutput("t3Ack", {24'd0, ack1}, 32'h80);
      src = 8'h00;
      repeat (2) applyStimulus();

      // Return while idle, unmapped read, write to a read-only register
      ret = 1'b1;
      applyStimulus();
      ret = 1'b0;
      checkOutput("t4NoAck", {24'd0, ack0}, 32'd0);
      busRead(32'h8);
      checkOutput("t4CauseIdle", bus0.read_data_o, 32'h0000_0007);
      busRead(32'h1C);
      checkOutput("t4Unmapped", bus0.read_data_o, 32'd0);
      busWrite(32'h4, 32'hFFFF_FFFF);
      busRead(32'h4);
      checkOutput("t4PendRo", bus0.read_data_o, 32'd0);
      busRead(32'h0);
      checkOutput("t4Mask", bus0.read_data_o, 32'h80);

      // Source and mask withdrawn during service: service still completes
      busWrite(32'h0, 32'h02);
      src = 8'h02;
      applyStimulus();
      applyStimulus();
      checkOutput("t5Req", {31'd0, req0}, 32'd1);
      src = 8'h00;
      busWrite(32'h0, 32'h00);
      applyStimulus();
      checkOutput("t5ReqHeld", {31'd0, req0}, 32'd1);
      ret = 1'b1;
      applyStimulus();
      ret = 1'b0;
      checkOutput("t5Ack", {24'd0, ack0}, 32'h02);
      repeat (2) applyStimulus();

      // Asynchronous reset in the middle of a service
      busWrite(32'h0, 32'h10);
      src = 8'h10;
      applyStimulus();
      applyStimulus();
      checkOutput("t6Req", {31'd0, req0}, 32'd1);
      #2;
      resetn = 1'b0;
      #1;
      resetModel();
      checkOutput("t6RstReq", {31'd0, req0}, 32'd0);
      checkOutput("t6RstAck", {24'd0, ack0}, 32'd0);
      checkOutput("t6RstReqRr", {31'd0, req1}, 32'd0);
      src = 8'h00;
      @(negedge clk) resetn = 1'b1;
      busRead(32'h0);
      checkOutput("t6Mask", bus0.read_data_o, 32'd0);

      // Random traffic against the model
      for (int c = 0; c < 400; c++) begin
         src = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
         ret = ($urandom_range(0, 2) == 0);
         busReq = ($urandom_range(0, 3) == 0);
         busWe = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 3))
            0: busAddr = 32'h0;
            1: busAddr = 32'h4;
            2: busAddr = 32'h8;
            default: busAddr = 32'h1C;
         endcase
         busWdata = $urandom;
         applyStimulus();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
